// File: rtl/systolic_ctrl_pkg.sv
// Shared types and width helpers for the weight-stationary array sequencer.
package systolic_ctrl_pkg;

    typedef enum logic [1:0] {
        S_PASSTHROUGH = 2'd0,
        S_LOAD        = 2'd1,
        S_PROCESS     = 2'd2
    } input_mux_t;

    typedef enum logic [2:0] {
        C_IDLE,
        C_SHIFT,
        C_LATCH,
        C_COMPUTE,
        C_DONE
    } ctrl_state_t;

    // One spare bit keeps len + ROWS + COLS - 2 from wrapping at the largest len.
    function automatic int phase_width(int len_w, int rows, int cols);
        int edge_w;
        edge_w = $clog2(rows + cols);
        return ((len_w > edge_w) ? len_w : edge_w) + 1;
    endfunction

    function automatic int row_idx_width(int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/systolic_ctrl_if.sv
// Job request and array control bundle between a requester and systolic_ctrl.
interface systolic_ctrl_if #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int LEN_W = 8
);
    localparam int RW = systolic_ctrl_pkg::row_idx_width(ROWS);

    logic                          start_i;
    logic                          reuse_w_i;
    logic [LEN_W-1:0]              len_i;
    logic                          busy_o;
    logic                          done_o;
    systolic_ctrl_pkg::input_mux_t mux_o;
    logic [ROWS-1:0]               add_zero_o;
    logic                          w_rd_o;
    logic [RW-1:0]                 w_row_o;
    logic [ROWS-1:0]               act_valid_o;
    logic [COLS-1:0]               res_valid_o;

    modport master (
        output start_i, reuse_w_i, len_i,
        input  busy_o, done_o, mux_o, add_zero_o, w_rd_o, w_row_o,
               act_valid_o, res_valid_o
    );

    modport slave (
        input  start_i, reuse_w_i, len_i,
        output busy_o, done_o, mux_o, add_zero_o, w_rd_o, w_row_o,
               act_valid_o, res_valid_o
    );

endinterface

// File: rtl/systolic_ctrl_skew_window.sv
// Half-open phase window: high while OFFSET <= t < OFFSET + k.
module skew_window #(
    parameter int OFFSET = 0,
    parameter int TW     = 9,
    parameter int LEN_W  = 8
) (
    input  logic [TW-1:0]    t,
    input  logic [LEN_W-1:0] k,
    output logic             hit
);
    localparam logic [TW-1:0] OFF = TW'(OFFSET);

    logic [TW-1:0] k_ext;
    assign k_ext = TW'(k);

    // A zero offset makes the lower bound trivially true for an unsigned phase.
    generate
        if (OFFSET == 0) begin : g_no_lower
            assign hit = (t < k_ext);
        end else begin : g_window
            assign hit = (t >= OFF) && (t < OFF + k_ext);
        end
    endgenerate

endmodule

// File: rtl/systolic_ctrl.sv
// Job sequencer for a ROWS x COLS weight-stationary pe array: weight shift, latch,
// skewed activation streaming and per-column result strobes.
module systolic_ctrl
    import systolic_ctrl_pkg::*;
#(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int LEN_W = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    systolic_ctrl_if.slave bus
);
    localparam int TW = phase_width(LEN_W, ROWS, COLS);
    localparam int RW = row_idx_width(ROWS);
    localparam logic [TW-1:0] T_LAST_BASE = TW'(ROWS + COLS - 2);

    ctrl_state_t      state;
    logic [LEN_W-1:0] k;
    logic [TW-1:0]    t;
    logic [RW-1:0]    w_row;
    logic [TW-1:0]    t_last;

    assign t_last = TW'(k) + T_LAST_BASE;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= C_IDLE;
            k     <= '0;
            t     <= '0;
            w_row <= '0;
        end else begin
            case (state)
                C_IDLE: begin
                    if (bus.start_i) begin
                        k <= bus.len_i;
                        t <= '0;
                        if (bus.reuse_w_i) begin
                            state <= (bus.len_i != '0) ? C_COMPUTE : C_DONE;
                        end else if (ROWS > 1) begin
                            state <= C_SHIFT;
                            w_row <= RW'(ROWS - 1);
                        end else begin
                            state <= C_LATCH;
                            w_row <= '0;
                        end
                    end
                end
                // Bottom row goes first so it has travelled furthest when LATCH fires.
                C_SHIFT: begin
                    if (w_row == RW'(1)) begin
                        state <= C_LATCH;
                        w_row <= '0;
                    end else begin
                        w_row <= w_row - RW'(1);
                    end
                end
                C_LATCH: begin
                    t     <= '0;
                    state <= (k != '0) ? C_COMPUTE : C_DONE;
                end
                C_COMPUTE: begin
                    if (t == t_last) begin
                        state <= C_DONE;
                        t     <= '0;
                    end else begin
                        t <= t + TW'(1);
                    end
                end
                C_DONE:  state <= C_IDLE;
                default: state <= C_IDLE;
            endcase
        end
    end

    logic [ROWS-1:0] act_hit;
    logic [COLS-1:0] res_hit;

    generate
        for (genvar r = 0; r < ROWS; r++) begin : g_row_win
            skew_window #(.OFFSET(r), .TW(TW), .LEN_W(LEN_W)) u_act_win (
                .t   (t),
                .k   (k),
                .hit (act_hit[r])
            );
        end
        for (genvar c = 0; c < COLS; c++) begin : g_col_win
            skew_window #(.OFFSET(ROWS + c), .TW(TW), .LEN_W(LEN_W)) u_res_win (
                .t   (t),
                .k   (k),
                .hit (res_hit[c])
            );
        end
    endgenerate

    logic            in_compute;
    logic            w_rd;
    input_mux_t      mux;
    logic [ROWS-1:0] add_zero;

    assign in_compute = (state == C_COMPUTE);
    assign w_rd       = (state == C_SHIFT) || (state == C_LATCH);

    // Only row 0 starts a fresh sum; lower rows accumulate what arrives from above.
    always_comb begin
        mux      = S_PASSTHROUGH;
        add_zero = '1;
        case (state)
            C_LATCH: mux = S_LOAD;
            C_COMPUTE: begin
                mux         = S_PROCESS;
                add_zero    = '0;
                add_zero[0] = 1'b1;
            end
            default: mux = S_PASSTHROUGH;
        endcase
    end

    assign bus.busy_o      = (state != C_IDLE);
    assign bus.done_o      = (state == C_DONE);
    assign bus.mux_o       = mux;
    assign bus.add_zero_o  = add_zero;
    assign bus.w_rd_o      = w_rd;
    assign bus.w_row_o     = w_rd ? w_row : '0;
    assign bus.act_valid_o = in_compute ? act_hit : '0;
    assign bus.res_valid_o = in_compute ? res_hit : '0;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Scoreboard bench for systolic_ctrl: jobs push hand-computed profiles, a monitor
// measures each observed job and compares it when busy_o falls.
module tb_systolic_ctrl;
    import systolic_ctrl_pkg::*;

    typedef struct {
        int aborted;
        int latency;
        int wrd;
        int wrow_seq;
        int load_idx;
        int load_cnt;
        int comp;
        int a2f;
        int a2c;
        int r0f;
        int r0c;
        int r3f;
        int r3c;
    } job_t;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;
    int   job_no;
    job_t sb[$];

    systolic_ctrl_if #(.ROWS(4), .COLS(4), .LEN_W(8)) bus ();

    systolic_ctrl #(.ROWS(4), .COLS(4), .LEN_W(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic job_t mkJob(int ab, int lat, int wrd, int seq, int lidx, int lcnt,
                                   int comp, int a2f, int a2c, int r0f, int r0c,
                                   int r3f, int r3c);
        job_t j;
        j.aborted = ab;   j.latency = lat;  j.wrd = wrd;     j.wrow_seq = seq;
        j.load_idx = lidx; j.load_cnt = lcnt; j.comp = comp;
        j.a2f = a2f; j.a2c = a2c; j.r0f = r0f; j.r0c = r0c; j.r3f = r3f; j.r3c = r3c;
        return j;
    endfunction

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"}, int'(bus.busy_o), 0);
        checkOutput({tag, "_done"}, int'(bus.done_o), 0);
        checkOutput({tag, "_w_rd"}, int'(bus.w_rd_o), 0);
        checkOutput({tag, "_w_row"}, int'(bus.w_row_o), 0);
        checkOutput({tag, "_act_valid"}, int'(bus.act_valid_o), 0);
        checkOutput({tag, "_res_valid"}, int'(bus.res_valid_o), 0);
        checkOutput({tag, "_mux"}, int'(bus.mux_o), int'(S_PASSTHROUGH));
        checkOutput({tag, "_add_zero"}, int'(bus.add_zero_o), 15);
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int n = 0;
        while (bus.busy_o === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) checkOutput({tag, "_idle_timeout"}, 1, 0);
    endtask

    // Issue one job, then scramble len_i/reuse_w_i to show they were captured.
    task automatic applyStimulus(input string tag, input bit reuse, input int len, input job_t exp);
        sb.push_back(exp);
        @(negedge clk);
        bus.start_i   = 1'b1;
        bus.reuse_w_i = reuse;
        bus.len_i     = 8'(len);
        @(negedge clk);
        bus.start_i   = 1'b0;
        bus.reuse_w_i = ~reuse;
        bus.len_i     = ~(8'(len));
        waitIdle(tag, 400);
    endtask

    // Monitor: profile each busy window and compare against the scoreboard head.
    initial begin
        bit   in_job;
        int   n, done_cnt, latency, wrd, seq, lidx, lcnt, comp;
        int   a2f, a2c, r0f, r0c, r3f, r3c, ctl_bad;
        job_t exp;
        string p;
        in_job = 0;
        forever begin
            @(negedge clk);
            if (bus.busy_o === 1'b1) begin
                if (!in_job) begin
                    in_job = 1; n = 0; done_cnt = 0; latency = 0; wrd = 0; seq = 0;
                    lidx = -1; lcnt = 0; comp = 0; ctl_bad = 0;
                    a2f = -1; a2c = 0; r0f = -1; r0c = 0; r3f = -1; r3c = 0;
                end
                n++;
                if (bus.done_o) begin
                    done_cnt++;
                    latency = n;
                end
                if (bus.w_rd_o) begin
                    if (bus.mux_o == S_LOAD) begin
                        if (lcnt == 0) lidx = wrd;
                        lcnt++;
                    end
                    seq = seq * 4 + int'(bus.w_row_o);
                    wrd++;
                end else if (bus.w_row_o != 0 || bus.mux_o == S_LOAD) begin
                    ctl_bad++;
                end
                if (bus.mux_o == S_PROCESS) begin
                    if (bus.act_valid_o[2]) begin if (a2c == 0) a2f = comp; a2c++; end
                    if (bus.res_valid_o[0]) begin if (r0c == 0) r0f = comp; r0c++; end
                    if (bus.res_valid_o[3]) begin if (r3c == 0) r3f = comp; r3c++; end
                    if (bus.add_zero_o != 4'b0001 || bus.w_rd_o) ctl_bad++;
                    comp++;
                end else if (bus.add_zero_o != 4'hF || bus.act_valid_o != 0 ||
                             bus.res_valid_o != 0) begin
                    ctl_bad++;
                end
            end else if (in_job) begin
                in_job = 0;
                job_no++;
                p = $sformatf("job%0d", job_no);
                if (sb.size() == 0) begin
                    checkOutput({p, "_unexpected"}, 1, 0);
                end else begin
                    exp = sb.pop_front();
                    checkOutput({p, "_aborted"}, int'(done_cnt == 0), exp.aborted);
                    checkOutput({p, "_done_cnt"}, done_cnt, exp.aborted ? 0 : 1);
                    if (exp.aborted == 0) begin
                        checkOutput({p, "_latency"}, latency, exp.latency);
                        checkOutput({p, "_w_rd_cycles"}, wrd, exp.wrd);
                        checkOutput({p, "_w_row_seq"}, seq, exp.wrow_seq);
                        checkOutput({p, "_load_idx"}, lidx, exp.load_idx);
                        checkOutput({p, "_load_cnt"}, lcnt, exp.load_cnt);
                        checkOutput({p, "_compute_cycles"}, comp, exp.comp);
                        checkOutput({p, "_act2_first"}, a2f, exp.a2f);
                        checkOutput({p, "_act2_cnt"}, a2c, exp.a2c);
                        checkOutput({p, "_res0_first"}, r0f, exp.r0f);
                        checkOutput({p, "_res0_cnt"}, r0c, exp.r0c);
                        checkOutput({p, "_res3_first"}, r3f, exp.r3f);
                        checkOutput({p, "_res3_cnt"}, r3c, exp.r3c);
                        checkOutput({p, "_ctl_bad"}, ctl_bad, 0);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        job_t job_a, job_b, job_b2, job_e, job_c, job_d, job_abort;
        int   n;
        int   falls;
        bit   prev;

        // Hand-computed profiles for ROWS=COLS=4.
        job_a     = mkJob(0, 15, 4, 228, 3, 1, 10, 2, 3, 4, 3, 7, 3);
        job_b     = mkJob(0, 9, 0, 0, -1, 0, 8, 2, 1, 4, 1, 7, 1);
        job_b2    = mkJob(0, 10, 0, 0, -1, 0, 9, 2, 2, 4, 2, 7, 2);
        job_e     = mkJob(0, 1, 0, 0, -1, 0, 0, -1, 0, -1, 0, -1, 0);
        job_c     = mkJob(0, 5, 4, 228, 3, 1, 0, -1, 0, -1, 0, -1, 0);
        job_d     = mkJob(0, 267, 4, 228, 3, 1, 262, 2, 255, 4, 255, 7, 255);
        job_abort = mkJob(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        compared      = 0;
        mismatched    = 0;
        job_no        = 0;
        rst           = 1'b1;
        bus.start_i   = 1'b0;
        bus.reuse_w_i = 1'b0;
        bus.len_i     = '0;
        repeat (2) @(negedge clk);
        checkResetOutputs("por");
        rst = 1'b0;

        applyStimulus("job_a", 1'b0, 3, job_a);

        // Abort a job a few cycles into COMPUTE.
        sb.push_back(job_abort);
        @(negedge clk);
        bus.start_i = 1'b1; bus.reuse_w_i = 1'b0; bus.len_i = 8'd3;
        @(negedge clk);
        bus.start_i = 1'b0;
        n = 0;
        while (bus.mux_o != S_PROCESS && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) checkOutput("abort_reach_compute_timeout", 1, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkResetOutputs("abort");
        rst = 1'b0;

        applyStimulus("job_a_again", 1'b0, 3, job_a);
        applyStimulus("job_reuse_k1", 1'b1, 1, job_b);
        applyStimulus("job_reuse_k2", 1'b1, 2, job_b2);
        applyStimulus("job_reuse_k0", 1'b1, 0, job_e);
        applyStimulus("job_k0", 1'b0, 0, job_c);

        // start_i held high: one job per IDLE visit, dropped during the second IDLE.
        sb.push_back(job_c);
        sb.push_back(job_c);
        @(negedge clk);
        bus.start_i = 1'b1; bus.reuse_w_i = 1'b0; bus.len_i = 8'd0;
        falls = 0; prev = 1'b0; n = 0;
        while (falls < 2 && n < 100) begin
            @(negedge clk);
            n++;
            if (prev && !bus.busy_o) falls++;
            prev = bus.busy_o;
        end
        bus.start_i = 1'b0;
        if (n >= 100) checkOutput("held_start_timeout", 1, 0);

        applyStimulus("job_k255", 1'b0, 255, job_d);

        repeat (5) @(negedge clk);
        checkOutput("sb_leftover", sb.size(), 0);
        checkOutput("jobs_observed", job_no, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
